// File: rtl/command_issuer.sv
// command_issuer: sends one opcode byte through a UART transmitter, waits for
// the remote response byte, checks it against the expected reply and keeps a
// host-side mirror of the remote LED.
// Optional feature macro: CMD_RETRY_EN -- when defined, a response timeout
// resends the opcode up to MAX_RETRY times before timeout_err is reported.
module command_issuer #(
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int MAX_RETRY      = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    input  logic [7:0] cmd_code,
    output logic       cmd_ready,
    output logic [7:0] tx_data,
    output logic       tx_start,
    input  logic       tx_done,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    output logic       done,
    output logic [7:0] resp_data,
    output logic       resp_ok,
    output logic       timeout_err,
    output logic       led_status,
    output logic [2:0] state
);

    // Counter only has to reach TIMEOUT_CYCLES-1.
    localparam int             CNT_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [7:0] OP_LED_ON  = 8'hA1;
    localparam logic [7:0] OP_LED_OFF = 8'hA2;
    localparam logic [7:0] OP_STATUS  = 8'hB1;
    localparam logic [7:0] OP_RESET   = 8'hC1;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SEND      = 3'd1,
        ST_WAIT_TX   = 3'd2,
        ST_WAIT_RESP = 3'd3,
        ST_DONE      = 3'd4
    } state_t;

    if (TIMEOUT_CYCLES < 2 || MAX_RETRY < 0) begin : g_bad_params
        $error("command_issuer: TIMEOUT_CYCLES must be >= 2 and MAX_RETRY >= 0");
    end

    // Expected reply for each opcode; the status read accepts 00 or 01.
    function automatic logic resp_match(input logic [7:0] op, input logic [7:0] rx);
        logic m;
        case (op)
            OP_LED_ON:  m = (rx == 8'h55);
            OP_LED_OFF: m = (rx == 8'hEE);
            OP_STATUS:  m = (rx[7:1] == 7'd0);
            OP_RESET:   m = (rx == 8'hAA);
            default:    m = (rx == 8'hEE);
        endcase
        return m;
    endfunction

    // New LED mirror value after a matching reply.
    function automatic logic led_next(input logic [7:0] op, input logic [7:0] rx,
                                      input logic cur);
        logic l;
        case (op)
            OP_LED_ON:  l = 1'b1;
            OP_LED_OFF: l = 1'b0;
            OP_RESET:   l = 1'b0;
            OP_STATUS:  l = rx[0];
            default:    l = cur;
        endcase
        return l;
    endfunction

    state_t           r_state;
    logic [7:0]       r_tx_data;     // doubles as the latched opcode
    logic             r_tx_start;
    logic             r_done;
    logic [7:0]       r_resp_data;
    logic             r_resp_ok;
    logic             r_timeout_err;
    logic             r_led;
    logic             r_cmd_ready;
    logic [CNT_W-1:0] r_cnt;
    logic             w_match;

`ifdef CMD_RETRY_EN
    localparam int             RTY_W   = (MAX_RETRY > 1) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [RTY_W-1:0] RTY_MAX = RTY_W'(MAX_RETRY);
    logic [RTY_W-1:0] r_retry;
`endif

    assign w_match = resp_match(r_tx_data, rx_data);

    // Transaction FSM with all outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_tx_data     <= 8'h00;
            r_tx_start    <= 1'b0;
            r_done        <= 1'b0;
            r_resp_data   <= 8'h00;
            r_resp_ok     <= 1'b0;
            r_timeout_err <= 1'b0;
            r_led         <= 1'b0;
            r_cmd_ready   <= 1'b0;
            r_cnt         <= '0;
`ifdef CMD_RETRY_EN
            r_retry       <= '0;
`endif
        end else begin
            r_tx_start <= 1'b0;
            r_done     <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        r_tx_data   <= cmd_code;
                        r_tx_start  <= 1'b1;
                        r_cmd_ready <= 1'b0;
                        r_state     <= ST_SEND;
`ifdef CMD_RETRY_EN
                        r_retry     <= '0;
`endif
                    end else begin
                        r_cmd_ready <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                ST_SEND: begin
                    r_state <= ST_WAIT_TX;
                end
                ST_WAIT_TX: begin
                    if (tx_done) begin
                        r_cnt   <= '0;
                        r_state <= ST_WAIT_RESP;
                    end else begin
                        r_state <= ST_WAIT_TX;
                    end
                end
                ST_WAIT_RESP: begin
                    // A reply on the last counted cycle still wins over the timeout.
                    if (rx_valid) begin
                        r_resp_data   <= rx_data;
                        r_resp_ok     <= w_match;
                        r_timeout_err <= 1'b0;
                        if (w_match) begin
                            r_led <= led_next(r_tx_data, rx_data, r_led);
                        end else begin
                            r_led <= r_led;
                        end
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end else if (r_cnt == CNT_LAST) begin
`ifdef CMD_RETRY_EN
                        if (r_retry < RTY_MAX) begin
                            r_retry    <= r_retry + RTY_W'(1);
                            r_tx_start <= 1'b1;
                            r_state    <= ST_SEND;
                        end else begin
`else
                        begin
`endif
                            r_resp_data   <= 8'h00;
                            r_resp_ok     <= 1'b0;
                            r_timeout_err <= 1'b1;
                            r_done        <= 1'b1;
                            r_state       <= ST_DONE;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    r_cmd_ready <= 1'b1;
                    r_state     <= ST_IDLE;
                end
                default: begin
                    r_cmd_ready <= 1'b1;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready   = r_cmd_ready;
    assign tx_data     = r_tx_data;
    assign tx_start    = r_tx_start;
    assign done        = r_done;
    assign resp_data   = r_resp_data;
    assign resp_ok     = r_resp_ok;
    assign timeout_err = r_timeout_err;
    assign led_status  = r_led;
    assign state       = r_state;

endmodule

// File: tb/tb_command_issuer.sv
// Directed bench for command_issuer: a table of full transactions plus
// hand-written sequences for ignored inputs, timeout and mid-transaction reset.
module tb_command_issuer;

    localparam int TO_CYC = 20;
    localparam int N_RTY  = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic [7:0] cmd_code = 8'h00;
    logic       cmd_ready;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_done = 1'b0;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       done;
    logic [7:0] resp_data;
    logic       resp_ok;
    logic       timeout_err;
    logic       led_status;
    logic [2:0] state;

    command_issuer #(.TIMEOUT_CYCLES(TO_CYC), .MAX_RETRY(N_RTY)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_code(cmd_code),
        .cmd_ready(cmd_ready), .tx_data(tx_data), .tx_start(tx_start),
        .tx_done(tx_done), .rx_valid(rx_valid), .rx_data(rx_data), .done(done),
        .resp_data(resp_data), .resp_ok(resp_ok), .timeout_err(timeout_err),
        .led_status(led_status), .state(state)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;
    int n_tx_start = 0;
    int n_done = 0;

    always @(negedge clk) begin
        if (tx_start === 1'b1) n_tx_start <= n_tx_start + 1;
        if (done === 1'b1) n_done <= n_done + 1;
    end

    typedef struct {
        logic [7:0] code;
        int         delay;
        logic [7:0] rx;
        logic [7:0] exp_data;
        logic       exp_ok;
        logic       exp_led;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else n_pass++;
    endtask

    // Issue a command from IDLE; returns at the negedge where WAIT_TX is shown.
    task automatic issue_cmd(input logic [7:0] code);
        int c;
        c = 0;
        while (cmd_ready !== 1'b1 && c < 20) begin
            @(negedge clk);
            c++;
        end
        chk("cmd_ready_before_cmd", {31'd0, cmd_ready}, 32'd1);
        cmd_valid = 1'b1;
        cmd_code  = code;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("send_state", {29'd0, state}, 32'd1);
        chk("send_tx_start", {31'd0, tx_start}, 32'd1);
        chk("send_tx_data", {24'd0, tx_data}, {24'd0, code});
        @(negedge clk);
        chk("wait_tx_state", {29'd0, state}, 32'd2);
    endtask

    task automatic give_tx_done();
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        int s0;
        s0 = n_tx_start;
        issue_cmd(v.code);
        give_tx_done();
        repeat (v.delay) @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = v.rx;
        @(negedge clk);
        rx_valid = 1'b0;
        chk("done_pulse", {31'd0, done}, 32'd1);
        chk("resp_data", {24'd0, resp_data}, {24'd0, v.exp_data});
        chk("resp_ok", {31'd0, resp_ok}, {31'd0, v.exp_ok});
        chk("timeout_err_clear", {31'd0, timeout_err}, 32'd0);
        chk("led_status", {31'd0, led_status}, {31'd0, v.exp_led});
        @(negedge clk);
        chk("done_one_cycle", {31'd0, done}, 32'd0);
        chk("back_to_idle", {29'd0, state}, 32'd0);
        chk("one_tx_start", n_tx_start - s0, 32'd1);
    endtask

    initial begin
        int cyc;
        int s0;
        int d0;
        vecs[0]  = '{8'hA1, 10, 8'h55, 8'h55, 1'b1, 1'b1};
        vecs[1]  = '{8'hB1,  3, 8'h01, 8'h01, 1'b1, 1'b1};
        vecs[2]  = '{8'hA2,  0, 8'hEE, 8'hEE, 1'b1, 1'b0};
        vecs[3]  = '{8'hC1,  5, 8'h55, 8'h55, 1'b0, 1'b0};
        vecs[4]  = '{8'h7F,  2, 8'hEE, 8'hEE, 1'b1, 1'b0};
        vecs[5]  = '{8'hA1, 19, 8'h55, 8'h55, 1'b1, 1'b1};
        vecs[6]  = '{8'hB1,  1, 8'h00, 8'h00, 1'b1, 1'b0};
        vecs[7]  = '{8'hB1,  1, 8'h02, 8'h02, 1'b0, 1'b0};
        vecs[8]  = '{8'hA1,  7, 8'h55, 8'h55, 1'b1, 1'b1};
        vecs[9]  = '{8'hC1,  4, 8'hAA, 8'hAA, 1'b1, 1'b0};
        vecs[10] = '{8'hA2,  2, 8'h55, 8'h55, 1'b0, 1'b0};
        vecs[11] = '{8'hA1,  2, 8'hEE, 8'hEE, 1'b0, 1'b0};
        vecs[12] = '{8'hFF,  1, 8'h55, 8'h55, 1'b0, 1'b0};

        // Reset values before any clock edge.
        #2;
        chk("rst_state", {29'd0, state}, 32'd0);
        chk("rst_tx_start", {31'd0, tx_start}, 32'd0);
        chk("rst_tx_data", {24'd0, tx_data}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_resp_data", {24'd0, resp_data}, 32'd0);
        chk("rst_resp_ok", {31'd0, resp_ok}, 32'd0);
        chk("rst_timeout_err", {31'd0, timeout_err}, 32'd0);
        chk("rst_led", {31'd0, led_status}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", {31'd0, cmd_ready}, 32'd1);

        // rx_valid in IDLE is ignored.
        rx_valid = 1'b1;
        rx_data  = 8'h55;
        @(negedge clk);
        rx_valid = 1'b0;
        chk("idle_rx_ignored_state", {29'd0, state}, 32'd0);
        chk("idle_rx_ignored_done", {31'd0, done}, 32'd0);

        for (int i = 0; i < 13; i++) run_vec(vecs[i]);

        // cmd_valid and rx_valid during WAIT_TX are ignored.
        s0 = n_tx_start;
        issue_cmd(8'hA2);
        cmd_valid = 1'b1;
        cmd_code  = 8'hA1;
        rx_valid  = 1'b1;
        rx_data   = 8'h55;
        @(negedge clk);
        cmd_valid = 1'b0;
        rx_valid  = 1'b0;
        chk("wait_tx_holds", {29'd0, state}, 32'd2);
        chk("wait_tx_opcode_kept", {24'd0, tx_data}, 32'h000000A2);
        give_tx_done();
        rx_valid = 1'b1;
        rx_data  = 8'hEE;
        @(negedge clk);
        rx_valid = 1'b0;
        chk("ignored_cmd_done", {31'd0, done}, 32'd1);
        chk("ignored_cmd_resp_ok", {31'd0, resp_ok}, 32'd1);
        chk("ignored_cmd_tx_starts", n_tx_start - s0, 32'd1);
        @(negedge clk);

        // Timeout: LED on first, then no reply.
        run_vec('{8'hA1, 1, 8'h55, 8'h55, 1'b1, 1'b1});
        s0 = n_tx_start;
        issue_cmd(8'hB1);
        give_tx_done();
        cyc = 0;
        while (done !== 1'b1 && cyc < 300) begin
            tx_done = (state == 3'd2);
            @(negedge clk);
            cyc++;
        end
        tx_done = 1'b0;
        chk("timeout_done", {31'd0, done}, 32'd1);
`ifdef CMD_RETRY_EN
        chk("timeout_cycles", cyc, TO_CYC + N_RTY * (TO_CYC + 2));
        chk("timeout_tx_starts", n_tx_start - s0, N_RTY + 1);
`else
        chk("timeout_cycles", cyc, TO_CYC);
        chk("timeout_tx_starts", n_tx_start - s0, 32'd1);
`endif
        chk("timeout_err_set", {31'd0, timeout_err}, 32'd1);
        chk("timeout_resp_ok", {31'd0, resp_ok}, 32'd0);
        chk("timeout_resp_data", {24'd0, resp_data}, 32'd0);
        chk("timeout_led_kept", {31'd0, led_status}, 32'd1);
        @(negedge clk);
        chk("timeout_back_idle", {29'd0, state}, 32'd0);

        // Reset in WAIT_RESP abandons the transaction.
        run_vec('{8'hA1, 1, 8'h55, 8'h55, 1'b1, 1'b1});
        issue_cmd(8'hB1);
        give_tx_done();
        repeat (3) @(negedge clk);
        d0 = n_done;
        rst_n = 1'b0;
        #1;
        chk("midrst_state", {29'd0, state}, 32'd0);
        chk("midrst_tx_start", {31'd0, tx_start}, 32'd0);
        chk("midrst_tx_data", {24'd0, tx_data}, 32'd0);
        chk("midrst_done", {31'd0, done}, 32'd0);
        chk("midrst_resp_data", {24'd0, resp_data}, 32'd0);
        chk("midrst_resp_ok", {31'd0, resp_ok}, 32'd0);
        chk("midrst_timeout_err", {31'd0, timeout_err}, 32'd0);
        chk("midrst_led", {31'd0, led_status}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_ready", {31'd0, cmd_ready}, 32'd1);
        repeat (TO_CYC + 5) @(negedge clk);
        chk("midrst_no_done", n_done - d0, 32'd0);
        chk("midrst_stays_idle", {29'd0, state}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/command_issuer.md
COMMAND_ISSUER -- requirements
Module: command_issuer

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 50000, the number of clk cycles to wait for a response byte before timing out.
REQ-002 SHALL have parameter MAX_RETRY, default 2, the number of resends after a timeout (used only when CMD_RETRY_EN is defined).
REQ-003 SHALL have port clk  input  1  system clock; one clock domain, all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port cmd_valid  input  1  host requests that a command byte be issued.
REQ-006 SHALL have port cmd_code  input  8  command opcode (A1 LED on, A2 LED off, B1 read status, C1 reset, any other value unknown).
REQ-007 SHALL have port cmd_ready  output  1  block accepts a command; high only in IDLE.
REQ-008 SHALL have port tx_data  output  8  byte to the UART transmitter.
REQ-009 SHALL have port tx_start  output  1  one-cycle pulse that starts a UART transmit.
REQ-010 SHALL have port tx_done  input  1  one-cycle pulse from the UART transmitter when the byte has been sent.
REQ-011 SHALL have port rx_valid  input  1  one-cycle pulse marking a received response byte.
REQ-012 SHALL have port rx_data  input  8  received response byte.
REQ-013 SHALL have port done  output  1  one-cycle pulse when a transaction ends.
REQ-014 SHALL have port resp_data  output  8  last response byte; 00 on timeout.
REQ-015 SHALL have port resp_ok  output  1  last response matched the expected value; valid with done and held until the next done.
REQ-016 SHALL have port timeout_err  output  1  last transaction ended by timeout; valid with done and held until the next done.
REQ-017 SHALL have port led_status  output  1  host-side mirror of the remote LED.
REQ-018 SHALL have port state  output  3  current FSM state encoding.

Function
REQ-019 SHALL use these FSM states: IDLE=0, SEND=1, WAIT_TX=2, WAIT_RESP=3, DONE=4; encodings 5-7 SHALL return to IDLE.
REQ-020 SHALL, in IDLE, on cmd_valid high, latch cmd_code, clear the retry count and enter SEND on the next cycle; a cmd_valid outside IDLE is ignored.
REQ-021 SHALL, in SEND, assert tx_start for exactly one cycle with tx_data equal to the latched opcode, then enter WAIT_TX.
REQ-022 SHALL, in WAIT_TX, hold until tx_done, then enter WAIT_RESP with the timeout counter at 0.
REQ-023 SHALL, in WAIT_RESP, increment the counter each cycle; rx_valid moves to DONE with resp_data=rx_data.
REQ-024 SHALL, when the counter reaches TIMEOUT_CYCLES-1 without rx_valid, treat the transaction as timed out; an rx_valid on that same cycle takes priority over the timeout.
REQ-025 SHALL use these expected responses: A1->55, A2->EE, B1->00 or 01, C1->AA, unknown opcode->EE; resp_ok=1 only on a match.
REQ-026 SHALL, on resp_ok only, update led_status: A1 sets it to 1; A2 and C1 set it to 0; B1 loads rx_data[0]; otherwise led_status is unchanged.
REQ-027 SHALL pulse done for one cycle in DONE, then enter IDLE; cmd_ready is low in DONE.
REQ-028 SHALL ignore rx_valid in IDLE, SEND, WAIT_TX and DONE.
REQ-029 SHALL, on timeout, set timeout_err=1, resp_ok=0 and resp_data=00.

Reset
REQ-030 SHALL, while rst_n=0, force state=IDLE, tx_start=0, tx_data=00, done=0, resp_data=00, resp_ok=0, timeout_err=0, led_status=0, and clear both counters, regardless of the clock.
REQ-031 SHALL, on reset asserted mid-transaction, abandon the transaction without a done pulse; cmd_ready goes high on the first clk after rst_n rises.

Configuration
REQ-032 SHALL, with CMD_RETRY_EN defined, on timeout while retry count < MAX_RETRY, increment the retry count and re-enter SEND (no done pulse); done with timeout_err follows only after MAX_RETRY+1 attempts.
REQ-033 SHALL, without CMD_RETRY_EN, go directly to DONE with timeout_err on the first timeout and exclude the retry counter from the design.

Verification
REQ-034 SHALL cover: cmd A1, tx_done, rx 55 after 10 cycles -> one tx_start with tx_data=A1, done, resp_ok=1, led_status=1.
REQ-035 SHALL cover: after LED on, cmd B1, rx 01 -> resp_data=01, resp_ok=1, led_status stays 1; then cmd A2, rx EE -> led_status=0.
REQ-036 SHALL cover: cmd C1, rx 55 -> resp_ok=0, led_status unchanged; cmd 7F, rx EE -> resp_ok=1.
REQ-037 SHALL cover: TIMEOUT_CYCLES=20, no rx -> without CMD_RETRY_EN, done 20 cycles after WAIT_RESP entry with timeout_err=1; with CMD_RETRY_EN and MAX_RETRY=2, 3 tx_start pulses before done.
REQ-038 SHALL cover: rx_valid on counter=TIMEOUT_CYCLES-1 -> response accepted, timeout_err=0; rst_n low in WAIT_RESP -> state=0 immediately, no done, all outputs at reset values.
